// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_if
//  Description : Bundle of the two-requester request/response handshake and
//                the operand/result bus towards the shared ALU.
//                slave  - the arbiter side
//                master - the environment side (requesters and ALU)
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int DATA_W = 32
);
    // Request side, bit i / suffix i belongs to requester i
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [5:0]        req_op0;
    logic [5:0]        req_op1;
    logic [DATA_W-1:0] req_a0;
    logic [DATA_W-1:0] req_b0;
    logic [DATA_W-1:0] req_a1;
    logic [DATA_W-1:0] req_b1;

    // Response side, rsp_data/rsp_err shared and qualified by rsp_valid
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    // ALU bus
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [5:0]        alu_signal;
    logic              alu_reset;
    logic [DATA_W-1:0] alu_out;

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        input  rsp_ready, alu_out,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output alu_a, alu_b, alu_signal, alu_reset
    );

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        output rsp_ready, alu_out,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  alu_a, alu_b, alu_signal, alu_reset
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin arbiter sharing one external ALU between two
//                requesters. One operation at a time: IDLE -> EXEC -> RESP.
//                Optional feature macro ALU_ARB_OPCHECK_EN: an accepted
//                non-legal opcode bypasses the ALU and answers with
//                rsp_err = 1, rsp_data = 0 one cycle after acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  wire logic    clk,
    input  wire logic    reset,
    alu_arbiter_if.slave bus
);

    localparam logic [5:0] C_OP_AND = 6'b100100;
    localparam logic [5:0] C_OP_OR  = 6'b100101;
    localparam logic [5:0] C_OP_ADD = 6'b100000;
    localparam logic [5:0] C_OP_SUB = 6'b100010;
    localparam logic [5:0] C_OP_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_ptr;
    logic              r_owner;
    logic [1:0]        r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [5:0]        r_alu_signal;

    logic [1:0]        w_grant;
    logic              w_sel;
    logic [5:0]        w_sel_op;
    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;
    logic              w_illegal;

    // Pick the winner: a lone requester always wins, a tie goes to r_ptr
    always_comb begin
        w_grant = bus.req_valid;
        if (bus.req_valid == 2'b11) begin
            w_grant = r_ptr ? 2'b10 : 2'b01;
        end
    end

    assign w_sel    = w_grant[1];
    assign w_sel_op = w_sel ? bus.req_op1 : bus.req_op0;
    assign w_sel_a  = w_sel ? bus.req_a1  : bus.req_a0;
    assign w_sel_b  = w_sel ? bus.req_b1  : bus.req_b0;

    // Accept only while idle and out of reset, and only towards the winner
    assign bus.req_ready = ((r_state == ST_IDLE) && reset) ? w_grant : 2'b00;

`ifdef ALU_ARB_OPCHECK_EN
    logic r_rsp_err;
    logic w_legal;

    assign w_legal   = (w_sel_op == C_OP_AND) || (w_sel_op == C_OP_OR) ||
                       (w_sel_op == C_OP_ADD) || (w_sel_op == C_OP_SUB) ||
                       (w_sel_op == C_OP_SLT);
    assign w_illegal = ~w_legal;
    assign bus.rsp_err = r_rsp_err;
`else
    // Without the opcode check every code goes through the ALU
    assign w_illegal   = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // Control FSM with all its outputs registered; ALU bus only moves on accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= 1'b0;
            r_owner      <= 1'b0;
            r_rsp_valid  <= 2'b00;
            r_rsp_data   <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_signal <= C_OP_ADD;
`ifdef ALU_ARB_OPCHECK_EN
            r_rsp_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_owner <= w_sel;
                        if (w_illegal) begin
                            // Bypass the ALU entirely; its bus keeps its value
                            r_rsp_data  <= '0;
                            r_rsp_valid <= w_grant;
`ifdef ALU_ARB_OPCHECK_EN
                            r_rsp_err   <= 1'b1;
`endif
                            r_state     <= ST_RESP;
                        end else begin
                            r_alu_signal <= w_sel_op;
                            r_alu_a      <= w_sel_a;
                            r_alu_b      <= w_sel_b;
                            r_state      <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    r_rsp_data  <= bus.alu_out;
`ifdef ALU_ARB_OPCHECK_EN
                    r_rsp_err   <= 1'b0;
`endif
                    r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    // Only the owner's rsp_ready can complete the response
                    if (|(r_rsp_valid & bus.rsp_ready)) begin
                        r_rsp_valid <= 2'b00;
                        r_ptr       <= ~r_owner;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_signal = r_alu_signal;
    assign bus.alu_reset  = ~reset;

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, operand and result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester request accept.
REQ-006 req_op0, req_op1  input  6 each  ALU function code per requester.
REQ-007 req_a0, req_b0, req_a1, req_b1  input  32 each  operands per requester.
REQ-008 rsp_valid  output  2  per-requester result valid.
REQ-009 rsp_ready  input  2  per-requester result accept.
REQ-010 rsp_data  output  32  result, shared by both requesters, qualified by rsp_valid.
REQ-011 rsp_err  output  1  illegal-opcode flag, qualified by rsp_valid.
REQ-012 alu_a, alu_b  output  32 each  operands to the ALU dataA/dataB.
REQ-013 alu_signal  output  6  function code to the ALU signal input.
REQ-014 alu_reset  output  1  active-high reset to the ALU; equals NOT reset.
REQ-015 alu_out  input  32  ALU dataOut.

Function
REQ-016 Legal codes: AND 6'b100100, OR 6'b100101, ADD 6'b100000, SUB 6'b100010, SLT 6'b101010.
REQ-017 States: IDLE, EXEC, RESP; a one-hot or binary encoding is permitted.
REQ-018 IDLE: the winner is chosen among the asserted req_valid bits; req_ready is driven combinationally, only to the winner, and only in IDLE.
REQ-019 Arbitration is round-robin: a 1-bit priority pointer favours requester ptr; a lone requester always wins.
REQ-020 On a handshake (req_valid[i] AND req_ready[i]), the winner's op, a and b are registered onto alu_signal/alu_a/alu_b, the owner is set to i, and the state moves to EXEC.
REQ-021 EXEC lasts 1 cycle; at its end alu_out is registered into rsp_data, rsp_err is set to 0, and the state moves to RESP.
REQ-022 RESP: rsp_valid[owner] = 1 and the other bit = 0; rsp_data and rsp_err stay stable until rsp_ready[owner].
REQ-023 RESP exit: on rsp_valid AND rsp_ready, the state goes to IDLE and ptr is set to NOT owner; a new request is accepted no earlier than the next cycle.
REQ-024 Latency: handshake in cycle N gives rsp_valid in cycle N+2; the minimum issue interval is 3 cycles.
REQ-025 alu_a/alu_b/alu_signal hold their last values outside EXEC; no glitch-driven updates.
REQ-026 A requester may drop req_valid before a grant without side effects; a non-owner's rsp_ready is ignored.
REQ-027 Simultaneous req_valid = 2'b11 in IDLE: only the ptr requester gets req_ready; the other waits.

Reset
REQ-028 While reset is low: state = IDLE, ptr = 0, owner = 0, req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, alu_a = 0, alu_b = 0, alu_signal = 6'b100000, alu_reset = 1.
REQ-029 Reset asserted mid-operation (EXEC or RESP) aborts the operation; no response is ever delivered for it.

Configuration
REQ-030 Macro ALU_ARB_OPCHECK_EN, when defined: an accepted non-legal opcode skips EXEC, goes IDLE to RESP with rsp_data = 0 and rsp_err = 1, and leaves the alu_* outputs unchanged.
REQ-031 Without ALU_ARB_OPCHECK_EN: rsp_err is tied to 0 and every opcode follows the IDLE, EXEC, RESP path unchanged.

Verification
REQ-032 Req0 ADD a=5, b=7, rsp_ready=1 -> req_ready[0] in cycle N, rsp_valid[0] in N+2, rsp_data=12, rsp_err=0.
REQ-033 Both valid after reset, req0 SUB 10-3, req1 SLT 2<9 -> req0 served first (rsp_data=7), then req1 (rsp_data=1); the grant order alternates thereafter.
REQ-034 Req1 AND 0xF0F0_F0F0 & 0xFF00_FF00 with rsp_ready=0 for 5 cycles -> rsp_valid[1] and rsp_data=0xF000_F000 held stable; no req_ready during the stall.
REQ-035 reset driven low during EXEC -> all outputs at reset values in the same cycle; no rsp_valid after release.
REQ-036 With ALU_ARB_OPCHECK_EN, req0 op 6'b000000 -> rsp_valid[0] in N+1, rsp_err=1, rsp_data=0; without the macro -> rsp_err=0 in N+2.
